pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register, the successor to the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a packed control bus and a packed data bus through DEPTH register slots, each with a valid bit, and adds stall (hold), bubble insertion, full flush and saturating stall/flush event counters. One instance per stage boundary replaces the hand-written latches and provides hazard-unit hooks.

Parameters:
CTRL_W, 16, width of packed control bus (ALUSrc, ALUop, RegDst, Branch, MemWrite, MemRead, MemToReg, RegWrite, ...)
DATA_W, 128, width of packed data bus (operands, PC+4, sign-extended immediate, rt/rd fields)
DEPTH, 1, number of register slots in series (1..4); latency in cycles
CNT_W, 16, width of each event counter

Ports:
Clk  in  1  rising-edge clock
Reset  in  1  synchronous, active-high reset
Stall  in  1  hold all slots this cycle
Flush  in  1  insert bubble into slot 0 this cycle
FlushAll  in  1  kill every in-flight slot this cycle
ValidIn  in  1  incoming instruction is real
CtrlIn  in  CTRL_W  incoming control bits
DataIn  in  DATA_W  incoming data bits
ValidOut  out  1  valid bit of last slot
CtrlOut  out  CTRL_W  control of last slot
DataOut  out  DATA_W  data of last slot
Busy  out  1  OR of all slot valid bits (combinational from slot regs)
StallCount  out  CNT_W  cycles with Stall=1
FlushCount  out  CNT_W  cycles with Flush=1 or FlushAll=1

Behaviour:
- Slots s0..s(DEPTH-1); s0 loads from inputs, s(k) loads from s(k-1); outputs are s(DEPTH-1). Latency is DEPTH cycles, no combinational input-to-output path.
- Reset (sync, rising edge): every valid=0, ctrl=0, data=0, both counters=0. Reset overrides all other inputs, including mid-stall.
- Per-edge priority: Reset > FlushAll > Stall/Flush > normal advance.
- FlushAll=1: all slots valid=0, ctrl=0; data is held. Applies regardless of Stall.
- Stall=1, Flush=0: all slots hold valid/ctrl/data unchanged; input is dropped (upstream holds it).
- Stall=1, Flush=1: s1..s(DEPTH-1) hold; s0 valid=0, ctrl=0, data held.
- Stall=0, Flush=1: slots advance; s0 loads valid=0, ctrl=0, data=DataIn.
- Normal: all slots advance; s0 loads ValidIn, CtrlIn, DataIn.
- Bubble invariant: valid=0 implies ctrl=0 in every slot (no stray RegWrite/MemWrite). ValidIn=0 with nonzero CtrlIn still loads ctrl=0.
- Counters: StallCount +1 per edge with Stall=1; FlushCount +1 per edge with Flush|FlushAll. Both saturate at 2^CTRL... at 2^CNT_W-1 with no wrap. Counters are not cleared by flushes, only by Reset.
- DEPTH=1 is cycle-equivalent to the existing fixed stage latch plus stall/flush.

Decomposition:
- Package pipe_pkg: default widths, the control field bit-position constants for the ID/EX control bundle (ALUSRC_BIT, ALUOP_LSB/MSB, REGDST_BIT, BRANCH_BIT, MEMWRITE_BIT, MEMREAD_BIT, MEMTOREG_BIT, REGWRITE_BIT), and data field offsets (RD1, RD2, PCADD, SIGNEXT, RT, RD).
- One sub-module pipe_slot: a single valid/ctrl/data register with hold, load and bubble controls, instantiated DEPTH times via generate. Counters live in the top module.

Test Plan:
- Reset: drive CtrlIn=16'hFFFF, DataIn all ones, ValidIn=1, Reset=1 for 2 cycles -> ValidOut=0, CtrlOut=0, DataOut=0, counters=0, Busy=0.
- Pass-through, DEPTH=3: ValidIn=1, CtrlIn=16'h00A5, DataIn=128'h1234 at cycle 0 -> outputs appear exactly at cycle 3. Stream of 5 values arrives in order with no gaps.
- Stall: DEPTH=1, load 16'h0011, then Stall=1 for 4 cycles while CtrlIn=16'h0022 -> CtrlOut stays 16'h0011 and StallCount=4. The next unstalled edge shows 16'h0022.
- Load-use bubble: Stall=1 and Flush=1 together for 1 cycle with DEPTH=2 -> s1 holds, and ValidOut=0 with CtrlOut=0 one edge later. FlushCount=1 and StallCount=1.
- FlushAll with 3 valid slots (DEPTH=3) plus Stall=1 -> next edge Busy=0 and CtrlOut=0. DataOut equals its previous value.
- Saturation: CNT_W=4, hold Stall=1 for 20 cycles -> StallCount reaches 4'hF and stays. A Reset pulse then returns it to 0.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared widths, ID/EX control and data field positions, and slot action encoding
// for the parametrised inter-stage pipeline register.
package pipe_pkg;

    localparam int CTRL_W_DEF = 16;
    localparam int DATA_W_DEF = 128;
    localparam int DEPTH_DEF  = 1;
    localparam int CNT_W_DEF  = 16;

    // ID/EX control bundle bit positions
    localparam int ALUSRC_BIT   = 0;
    localparam int ALUOP_LSB    = 1;
    localparam int ALUOP_MSB    = 2;
    localparam int REGDST_BIT   = 3;
    localparam int BRANCH_BIT   = 4;
    localparam int MEMWRITE_BIT = 5;
    localparam int MEMREAD_BIT  = 6;
    localparam int MEMTOREG_BIT = 7;
    localparam int REGWRITE_BIT = 8;

    // Data bundle offsets; the immediate is carried as 16 bits and re-extended downstream
    localparam int RD1_LSB     = 0;
    localparam int RD2_LSB     = 32;
    localparam int PCADD_LSB   = 64;
    localparam int SIGNEXT_LSB = 96;
    localparam int RT_LSB      = 112;
    localparam int RD_LSB      = 117;

    typedef enum logic [1:0] {
        SLOT_LOAD = 2'd0,
        SLOT_HOLD = 2'd1,
        SLOT_KILL = 2'd2
    } slot_act_e;

    // Kill beats hold: a flush must clear control bits even while the pipe is frozen
    function automatic slot_act_e slotAction(input logic isHead, input logic stall,
                                             input logic flush, input logic flushAll);
        slot_act_e act;
        if (flushAll)
            act = SLOT_KILL;
        else if (stall && flush && isHead)
            act = SLOT_KILL;
        else if (stall)
            act = SLOT_HOLD;
        else
            act = SLOT_LOAD;
        return act;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Bundle of hazard controls, incoming instruction, outgoing instruction and event counters.
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    logic              Stall;
    logic              Flush;
    logic              FlushAll;
    logic              ValidIn;
    logic [CTRL_W-1:0] CtrlIn;
    logic [DATA_W-1:0] DataIn;
    logic              ValidOut;
    logic [CTRL_W-1:0] CtrlOut;
    logic [DATA_W-1:0] DataOut;
    logic              Busy;
    logic [CNT_W-1:0]  StallCount;
    logic [CNT_W-1:0]  FlushCount;

    modport master (
        output Stall, Flush, FlushAll, ValidIn, CtrlIn, DataIn,
        input  ValidOut, CtrlOut, DataOut, Busy, StallCount, FlushCount
    );

    modport slave (
        input  Stall, Flush, FlushAll, ValidIn, CtrlIn, DataIn,
        output ValidOut, CtrlOut, DataOut, Busy, StallCount, FlushCount
    );
endinterface

// File: rtl/pipe_stage_reg_slot.sv
// One pipeline slot: valid/ctrl/data register with load, hold and kill actions.
// A non-valid slot never carries nonzero control bits.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  slot_act_e         act_i,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);
    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [DATA_W-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        case (act_i)
            SLOT_LOAD: begin
                valid_d = valid_i;
                ctrl_d  = valid_i ? ctrl_i : '0;
                data_d  = data_i;
            end
            SLOT_KILL: begin
                valid_d = 1'b0;
                ctrl_d  = '0;
            end
            SLOT_HOLD: ;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: DEPTH slots in series with stall,
// bubble, full flush and saturating stall/flush event counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input logic             Clk,
    input logic             Reset,
    pipe_stage_reg_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [DEPTH-1:0]  slotValid;
    logic [CTRL_W-1:0] slotCtrl [DEPTH];
    logic [DATA_W-1:0] slotData [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        logic              vIn;
        logic [CTRL_W-1:0] cIn;
        logic [DATA_W-1:0] dIn;
        slot_act_e         act;

        // A flush that advances still takes the incoming data, but as a bubble
        if (k == 0) begin : g_head
            assign vIn = bus.ValidIn & ~bus.Flush;
            assign cIn = bus.CtrlIn;
            assign dIn = bus.DataIn;
        end else begin : g_body
            assign vIn = slotValid[k-1];
            assign cIn = slotCtrl[k-1];
            assign dIn = slotData[k-1];
        end

        assign act = slotAction(k == 0, bus.Stall, bus.Flush, bus.FlushAll);

        pipe_slot #(
            .CTRL_W (CTRL_W),
            .DATA_W (DATA_W)
        ) u_slot (
            .clk     (Clk),
            .reset   (Reset),
            .act_i   (act),
            .valid_i (vIn),
            .ctrl_i  (cIn),
            .data_i  (dIn),
            .valid_o (slotValid[k]),
            .ctrl_o  (slotCtrl[k]),
            .data_o  (slotData[k])
        );
    end

    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
    logic [CNT_W-1:0] flushCnt_q, flushCnt_d;

    always_comb begin
        stallCnt_d = stallCnt_q;
        flushCnt_d = flushCnt_q;
        if (bus.Stall && (stallCnt_q != CNT_MAX))
            stallCnt_d = stallCnt_q + 1'b1;
        if ((bus.Flush || bus.FlushAll) && (flushCnt_q != CNT_MAX))
            flushCnt_d = flushCnt_q + 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
            flushCnt_q <= flushCnt_d;
        end
    end

    assign bus.ValidOut   = slotValid[DEPTH-1];
    assign bus.CtrlOut    = slotCtrl[DEPTH-1];
    assign bus.DataOut    = slotData[DEPTH-1];
    assign bus.Busy       = |slotValid;
    assign bus.StallCount = stallCnt_q;
    assign bus.FlushCount = flushCnt_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: four instances (DEPTH 1/2/3 and a 4-bit counter
// variant) share one set of stimulus signals; each scenario checks the relevant instance.
module tb_pipe_stage_reg;
    logic         clk = 1'b0;
    logic         reset;
    logic         stall, flush, flushAll, validIn;
    logic [15:0]  ctrlIn;
    logic [127:0] dataIn;
    int           checkCount = 0;
    int           failCount  = 0;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.CTRL_W(16), .DATA_W(128), .CNT_W(16)) bus1 ();
    pipe_stage_reg_if #(.CTRL_W(16), .DATA_W(128), .CNT_W(16)) bus2 ();
    pipe_stage_reg_if #(.CTRL_W(16), .DATA_W(128), .CNT_W(16)) bus3 ();
    pipe_stage_reg_if #(.CTRL_W(16), .DATA_W(128), .CNT_W(4))  bus4 ();

    assign bus1.Stall = stall;   assign bus1.Flush = flush;   assign bus1.FlushAll = flushAll;
    assign bus1.ValidIn = validIn; assign bus1.CtrlIn = ctrlIn; assign bus1.DataIn = dataIn;
    assign bus2.Stall = stall;   assign bus2.Flush = flush;   assign bus2.FlushAll = flushAll;
    assign bus2.ValidIn = validIn; assign bus2.CtrlIn = ctrlIn; assign bus2.DataIn = dataIn;
    assign bus3.Stall = stall;   assign bus3.Flush = flush;   assign bus3.FlushAll = flushAll;
    assign bus3.ValidIn = validIn; assign bus3.CtrlIn = ctrlIn; assign bus3.DataIn = dataIn;
    assign bus4.Stall = stall;   assign bus4.Flush = flush;   assign bus4.FlushAll = flushAll;
    assign bus4.ValidIn = validIn; assign bus4.CtrlIn = ctrlIn; assign bus4.DataIn = dataIn;

    pipe_stage_reg #(.CTRL_W(16), .DATA_W(128), .DEPTH(1), .CNT_W(16)) dut1 (.Clk(clk), .Reset(reset), .bus(bus1));
    pipe_stage_reg #(.CTRL_W(16), .DATA_W(128), .DEPTH(2), .CNT_W(16)) dut2 (.Clk(clk), .Reset(reset), .bus(bus2));
    pipe_stage_reg #(.CTRL_W(16), .DATA_W(128), .DEPTH(3), .CNT_W(16)) dut3 (.Clk(clk), .Reset(reset), .bus(bus3));
    pipe_stage_reg #(.CTRL_W(16), .DATA_W(128), .DEPTH(1), .CNT_W(4))  dut4 (.Clk(clk), .Reset(reset), .bus(bus4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        stall = 0; flush = 0; flushAll = 0; validIn = 0; ctrlIn = '0; dataIn = '0;
    endtask

    task automatic applyReset();
        idleInputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        stall = 0; flush = 0; flushAll = 0;
        validIn = 1; ctrlIn = 16'hFFFF; dataIn = '1; reset = 1;
        tick();
        tick();
        checkCount++; if (bus1.ValidOut !== 1'b0) begin failCount++; $display("[TB] FAIL reset_valid1: got %b expected 0", bus1.ValidOut); end
        checkCount++; if (bus1.CtrlOut !== 16'h0) begin failCount++; $display("[TB] FAIL reset_ctrl1: got %h expected 0", bus1.CtrlOut); end
        checkCount++; if (bus1.DataOut !== 128'h0) begin failCount++; $display("[TB] FAIL reset_data1: got %h expected 0", bus1.DataOut); end
        checkCount++; if (bus3.DataOut !== 128'h0) begin failCount++; $display("[TB] FAIL reset_data3: got %h expected 0", bus3.DataOut); end
        checkCount++; if (bus3.Busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy3: got %b expected 0", bus3.Busy); end
        checkCount++; if (bus2.Busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy2: got %b expected 0", bus2.Busy); end
        checkCount++; if (bus1.StallCount !== 16'h0) begin failCount++; $display("[TB] FAIL reset_stallcnt: got %h expected 0", bus1.StallCount); end
        checkCount++; if (bus1.FlushCount !== 16'h0) begin failCount++; $display("[TB] FAIL reset_flushcnt: got %h expected 0", bus1.FlushCount); end
        idleInputs();
        reset = 0;
    endtask

    task automatic test_pass_through();
        applyReset();
        validIn = 1; ctrlIn = 16'h00A5; dataIn = 128'h1234;
        for (int e = 1; e <= 4; e++) begin
            tick();
            idleInputs();
            if (e == 3) begin
                checkCount++; if (bus3.ValidOut !== 1'b1) begin failCount++; $display("[TB] FAIL pass_valid_e3: got %b expected 1", bus3.ValidOut); end
                checkCount++; if (bus3.CtrlOut !== 16'h00A5) begin failCount++; $display("[TB] FAIL pass_ctrl_e3: got %h expected 00a5", bus3.CtrlOut); end
                checkCount++; if (bus3.DataOut !== 128'h1234) begin failCount++; $display("[TB] FAIL pass_data_e3: got %h expected 1234", bus3.DataOut); end
            end else begin
                checkCount++; if (bus3.ValidOut !== 1'b0) begin failCount++; $display("[TB] FAIL pass_valid_e%0d: got %b expected 0", e, bus3.ValidOut); end
            end
        end
        // Five back-to-back items; item i emerges after edge i+3
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (cyc < 5) begin
                validIn = 1; ctrlIn = 16'h0100 + 16'(cyc); dataIn = 128'hA000 + 128'(cyc);
            end else begin
                idleInputs();
            end
            tick();
            if (cyc >= 2 && cyc - 2 < 5) begin
                checkCount++; if (bus3.ValidOut !== 1'b1) begin failCount++; $display("[TB] FAIL stream_valid_%0d: got %b expected 1", cyc, bus3.ValidOut); end
                checkCount++; if (bus3.CtrlOut !== 16'h0100 + 16'(cyc - 2)) begin failCount++; $display("[TB] FAIL stream_ctrl_%0d: got %h expected %h", cyc, bus3.CtrlOut, 16'h0100 + 16'(cyc - 2)); end
                checkCount++; if (bus3.DataOut !== 128'hA000 + 128'(cyc - 2)) begin failCount++; $display("[TB] FAIL stream_data_%0d: got %h expected %h", cyc, bus3.DataOut, 128'hA000 + 128'(cyc - 2)); end
            end else begin
                checkCount++; if (bus3.ValidOut !== 1'b0) begin failCount++; $display("[TB] FAIL stream_gap_%0d: got %b expected 0", cyc, bus3.ValidOut); end
            end
        end
    endtask

    task automatic test_stall();
        applyReset();
        validIn = 1; ctrlIn = 16'h0011; dataIn = 128'h11;
        tick();
        checkCount++; if (bus1.CtrlOut !== 16'h0011) begin failCount++; $display("[TB] FAIL stall_load: got %h expected 0011", bus1.CtrlOut); end
        stall = 1; ctrlIn = 16'h0022; dataIn = 128'h22;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checkCount++; if (bus1.CtrlOut !== 16'h0011) begin failCount++; $display("[TB] FAIL stall_hold_ctrl_%0d: got %h expected 0011", i, bus1.CtrlOut); end
            checkCount++; if (bus1.DataOut !== 128'h11) begin failCount++; $display("[TB] FAIL stall_hold_data_%0d: got %h expected 11", i, bus1.DataOut); end
        end
        checkCount++; if (bus1.StallCount !== 16'd4) begin failCount++; $display("[TB] FAIL stall_count: got %0d expected 4", bus1.StallCount); end
        stall = 0;
        tick();
        checkCount++; if (bus1.CtrlOut !== 16'h0022) begin failCount++; $display("[TB] FAIL stall_release: got %h expected 0022", bus1.CtrlOut); end
        checkCount++; if (bus1.StallCount !== 16'd4) begin failCount++; $display("[TB] FAIL stall_count_after: got %0d expected 4", bus1.StallCount); end
        checkCount++; if (bus1.FlushCount !== 16'd0) begin failCount++; $display("[TB] FAIL stall_flushcnt: got %0d expected 0", bus1.FlushCount); end
        idleInputs();
    endtask

    task automatic test_bubble();
        applyReset();
        flush = 1; validIn = 1; ctrlIn = 16'h0055; dataIn = 128'h55;
        tick();
        checkCount++; if (bus1.ValidOut !== 1'b0) begin failCount++; $display("[TB] FAIL flush_valid: got %b expected 0", bus1.ValidOut); end
        checkCount++; if (bus1.CtrlOut !== 16'h0) begin failCount++; $display("[TB] FAIL flush_ctrl: got %h expected 0", bus1.CtrlOut); end
        checkCount++; if (bus1.DataOut !== 128'h55) begin failCount++; $display("[TB] FAIL flush_data: got %h expected 55", bus1.DataOut); end
        checkCount++; if (bus1.FlushCount !== 16'd1) begin failCount++; $display("[TB] FAIL flush_count: got %0d expected 1", bus1.FlushCount); end
        flush = 0; validIn = 0; ctrlIn = 16'hFFFF; dataIn = 128'h66;
        tick();
        checkCount++; if (bus1.CtrlOut !== 16'h0) begin failCount++; $display("[TB] FAIL invalid_ctrl: got %h expected 0", bus1.CtrlOut); end
        checkCount++; if (bus1.DataOut !== 128'h66) begin failCount++; $display("[TB] FAIL invalid_data: got %h expected 66", bus1.DataOut); end
        checkCount++; if (bus1.Busy !== 1'b0) begin failCount++; $display("[TB] FAIL invalid_busy: got %b expected 0", bus1.Busy); end
        idleInputs();
    endtask

    task automatic test_load_use();
        applyReset();
        validIn = 1; ctrlIn = 16'h00A1; dataIn = 128'hAA;
        tick();
        ctrlIn = 16'h00B2; dataIn = 128'hBB;
        tick();
        stall = 1; flush = 1; ctrlIn = 16'h00C3; dataIn = 128'hCC;
        tick();
        checkCount++; if (bus2.ValidOut !== 1'b1) begin failCount++; $display("[TB] FAIL lu_hold_valid: got %b expected 1", bus2.ValidOut); end
        checkCount++; if (bus2.CtrlOut !== 16'h00A1) begin failCount++; $display("[TB] FAIL lu_hold_ctrl: got %h expected 00a1", bus2.CtrlOut); end
        stall = 0; flush = 0;
        tick();
        checkCount++; if (bus2.ValidOut !== 1'b0) begin failCount++; $display("[TB] FAIL lu_bubble_valid: got %b expected 0", bus2.ValidOut); end
        checkCount++; if (bus2.CtrlOut !== 16'h0) begin failCount++; $display("[TB] FAIL lu_bubble_ctrl: got %h expected 0", bus2.CtrlOut); end
        checkCount++; if (bus2.DataOut !== 128'hBB) begin failCount++; $display("[TB] FAIL lu_bubble_data: got %h expected bb", bus2.DataOut); end
        checkCount++; if (bus2.FlushCount !== 16'd1) begin failCount++; $display("[TB] FAIL lu_flushcnt: got %0d expected 1", bus2.FlushCount); end
        checkCount++; if (bus2.StallCount !== 16'd1) begin failCount++; $display("[TB] FAIL lu_stallcnt: got %0d expected 1", bus2.StallCount); end
        idleInputs();
        tick();
        checkCount++; if (bus2.CtrlOut !== 16'h00C3) begin failCount++; $display("[TB] FAIL lu_resume: got %h expected 00c3", bus2.CtrlOut); end
    endtask

    task automatic test_flush_all();
        applyReset();
        for (int i = 0; i < 3; i++) begin
            validIn = 1; ctrlIn = 16'h0F00 + 16'(i); dataIn = 128'hD00 + 128'(i);
            tick();
        end
        checkCount++; if (bus3.Busy !== 1'b1) begin failCount++; $display("[TB] FAIL fa_busy_before: got %b expected 1", bus3.Busy); end
        checkCount++; if (bus3.CtrlOut !== 16'h0F00) begin failCount++; $display("[TB] FAIL fa_ctrl_before: got %h expected 0f00", bus3.CtrlOut); end
        flushAll = 1; stall = 1; ctrlIn = 16'h0F03; dataIn = 128'hD03;
        tick();
        checkCount++; if (bus3.Busy !== 1'b0) begin failCount++; $display("[TB] FAIL fa_busy: got %b expected 0", bus3.Busy); end
        checkCount++; if (bus3.ValidOut !== 1'b0) begin failCount++; $display("[TB] FAIL fa_valid: got %b expected 0", bus3.ValidOut); end
        checkCount++; if (bus3.CtrlOut !== 16'h0) begin failCount++; $display("[TB] FAIL fa_ctrl: got %h expected 0", bus3.CtrlOut); end
        checkCount++; if (bus3.DataOut !== 128'hD00) begin failCount++; $display("[TB] FAIL fa_data: got %h expected d00", bus3.DataOut); end
        checkCount++; if (bus3.FlushCount !== 16'd1) begin failCount++; $display("[TB] FAIL fa_flushcnt: got %0d expected 1", bus3.FlushCount); end
        idleInputs();
    endtask

    task automatic test_saturation();
        applyReset();
        stall = 1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            checkCount++;
            if (bus4.StallCount !== 4'((i > 15) ? 15 : i)) begin
                failCount++;
                $display("[TB] FAIL sat_count_%0d: got %h expected %h", i, bus4.StallCount, 4'((i > 15) ? 15 : i));
            end
        end
        validIn = 1; ctrlIn = 16'h0077;
        reset = 1;
        tick();
        reset = 0;
        checkCount++; if (bus4.StallCount !== 4'h0) begin failCount++; $display("[TB] FAIL sat_reset: got %h expected 0", bus4.StallCount); end
        checkCount++; if (bus1.ValidOut !== 1'b0) begin failCount++; $display("[TB] FAIL reset_mid_stall: got %b expected 0", bus1.ValidOut); end
        idleInputs();
    endtask

    initial begin
        reset = 0;
        idleInputs();
        test_reset();
        test_pass_through();
        test_stall();
        test_bubble();
        test_load_use();
        test_flush_all();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end
endmodule
